rf_write_sched: RTL and testbench

Write-port scheduler for the 16×16-bit register file. The file has one write port (C/Caddr/Load), so this block arbitrates it between two writeback requesters: ALU (port 0) and memory load (port 1). Each requester uses a valid/ready handshake, and arbitration is round-robin. The block registers the winning write onto the write port and, optionally, keeps a pending-write scoreboard that stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards. It sits between the writeback stage and the register file.

---
 rtl/rf_write_sched_pkg.sv | 22 ++
 rtl/rf_write_sched_if.sv | 38 +++
 rtl/rf_write_sched_rr_arb2.sv | 44 ++++
 rtl/rf_write_sched.sv | 116 +++++++++++
 tb/tb_rf_write_sched.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_sched_pkg.sv
// Shared types and defaults for the register-file write scheduler.
// Optional feature macro: RF_SCOREBOARD_EN (pending-write scoreboard).
package rf_sched_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;
  localparam int NUM_REGS  = 1 << RF_ADDR_W;

  // One writeback request as seen by the scheduler.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_id_t;

endpackage

// File: rtl/rf_write_sched_if.sv
// Writeback and reservation handshakes between the pipeline and the
// register-file write scheduler. Optional feature macro: RF_SCOREBOARD_EN.
interface rf_write_sched_if
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) ();

  logic              wb0_valid;
  logic              wb0_ready;
  logic [ADDR_W-1:0] wb0_addr;
  logic [DATA_W-1:0] wb0_data;

  logic              wb1_valid;
  logic              wb1_ready;
  logic [ADDR_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;

  logic              rsv_valid;
  logic              rsv_ready;
  logic [ADDR_W-1:0] rsv_addr;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rsv_valid, rsv_addr,
    input  wb0_ready, wb1_ready, rsv_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rsv_valid, rsv_addr,
    output wb0_ready, wb1_ready, rsv_ready
  );

endinterface

// File: rtl/rf_write_sched_rr_arb2.sv
// Two-input round-robin arbiter with a one-bit "last winner" pointer.
// The pointer only moves when both inputs contend and the grant is taken.
// Optional feature macro of the enclosing block: RF_SCOREBOARD_EN (unused here).
module rr_arb2
  import rf_sched_pkg::*;
(
  input  logic       clk,
  input  logic       clear_n_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  wb_id_t last_q, last_d;

  // Grant: a lone requester wins; on contention the port other than last wins.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == WB_MEM) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  // Pointer next state: record the winner of an accepted contested grant.
  always_comb begin
    last_d = last_q;
    if (accept_i && (req_i == 2'b11)) begin
      last_d = gnt_o[1] ? WB_MEM : WB_ALU;
    end
  end

  // Pointer register; reset value makes port 0 win the first conflict.
  always_ff @(posedge clk) begin
    if (!clear_n_i) begin
      last_q <= WB_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write-port scheduler: round-robin between ALU and memory
// writeback, registered write onto C/Caddr/Load, and an optional
// RAW/WAW scoreboard enabled by the macro RF_SCOREBOARD_EN.
module rf_write_sched
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              Clear,
  rf_write_sched_if.slave   wb,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  input  logic              Aen,
  input  logic              Ben,
  output logic              stall,
  output logic [DATA_W-1:0] C,
  output logic [ADDR_W-1:0] Caddr,
  output logic              Load
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              xfer;
  wb_id_t            win_id;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  logic              load_q, load_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;

  // Requests are masked during reset so no handshake completes then.
  assign req = {wb.wb1_valid, wb.wb0_valid} & {2{Clear}};

  rr_arb2 u_arb (
    .clk       (clk),
    .clear_n_i (Clear),
    .req_i     (req),
    .accept_i  (xfer),
    .gnt_o     (gnt)
  );

  assign wb.wb0_ready = gnt[0];
  assign wb.wb1_ready = gnt[1];
  assign xfer         = |gnt;
  assign win_id       = gnt[1] ? WB_MEM : WB_ALU;
  assign win_addr     = (win_id == WB_MEM) ? wb.wb1_addr : wb.wb0_addr;
  assign win_data     = (win_id == WB_MEM) ? wb.wb1_data : wb.wb0_data;

  // Write-port next state: pulse Load on a transfer, otherwise hold data.
  always_comb begin
    load_d  = xfer;
    c_d     = c_q;
    caddr_d = caddr_q;
    if (xfer) begin
      c_d     = win_data;
      caddr_d = win_addr;
    end
  end

  // Write-port register; reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (!Clear) begin
      load_q  <= 1'b0;
      c_q     <= '0;
      caddr_q <= '0;
    end else begin
      load_q  <= load_d;
      c_q     <= c_d;
      caddr_q <= caddr_d;
    end
  end

  assign Load  = load_q;
  assign C     = c_q;
  assign Caddr = caddr_q;

`ifdef RF_SCOREBOARD_EN
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] set_mask, clr_mask;
  logic            rsv_take;

  assign wb.rsv_ready = ~busy_q[wb.rsv_addr];
  assign rsv_take     = wb.rsv_valid & wb.rsv_ready;
  assign stall        = (Aen & busy_q[Aaddr]) | (Ben & busy_q[Baddr]);

  // Busy next state: writeback clears, reservation sets; set applied last wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (rsv_take) set_mask[wb.rsv_addr] = 1'b1;
    if (xfer)     clr_mask[win_addr]    = 1'b1;
    busy_d = (busy_q & ~clr_mask) | set_mask;
  end

  // Pending-write mask register.
  always_ff @(posedge clk) begin
    if (!Clear) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`else
  logic unused_sb;

  assign wb.rsv_ready = 1'b1;
  assign stall        = 1'b0;
  assign unused_sb    = ^{wb.rsv_valid, wb.rsv_addr, Aaddr, Baddr, Aen, Ben};
`endif

endmodule

// File: tb/tb_rf_write_sched.sv
// Self-checking bench for rf_write_sched: directed steps followed by a
// randomized phase, all checked against a cycle-level reference model.
// Honours the RF_SCOREBOARD_EN macro when choosing expectations.
module tb_rf_write_sched;
  import rf_sched_pkg::*;

`ifdef RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Clear;
  logic [3:0] Aaddr, Baddr;
  logic       Aen, Ben;
  logic       stall;
  logic [15:0] C;
  logic [3:0]  Caddr;
  logic        Load;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         m_last;
  bit         m_busy [16];
  bit         m_load;
  logic [15:0] m_c;
  logic [3:0]  m_caddr;

  rf_write_sched_if #(.DATA_W(16), .ADDR_W(4)) ifc ();

  rf_write_sched dut (
    .clk   (clk),
    .Clear (Clear),
    .wb    (ifc),
    .Aaddr (Aaddr),
    .Baddr (Baddr),
    .Aen   (Aen),
    .Ben   (Ben),
    .stall (stall),
    .C     (C),
    .Caddr (Caddr),
    .Load  (Load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_load  = 1'b0;
    m_c     = '0;
    m_caddr = '0;
    foreach (m_busy[k]) m_busy[k] = 1'b0;
  endtask

  // One clock cycle: check handshake outputs mid-cycle, advance the model
  // across the edge, then check the write port. Returns the granted port.
  task automatic cycle(output int win);
    bit exp_rsv, exp_stall, both;
    @(negedge clk);
    win  = -1;
    both = ifc.wb0_valid && ifc.wb1_valid;
    if (Clear) begin
      if (both)                win = (m_last == 1) ? 0 : 1;
      else if (ifc.wb0_valid)  win = 0;
      else if (ifc.wb1_valid)  win = 1;
    end
    if (SB) begin
      exp_rsv   = !m_busy[ifc.rsv_addr];
      exp_stall = (Aen && m_busy[Aaddr]) || (Ben && m_busy[Baddr]);
    end else begin
      exp_rsv   = 1'b1;
      exp_stall = 1'b0;
    end
    check("wb0_ready", ifc.wb0_ready, (win == 0));
    check("wb1_ready", ifc.wb1_ready, (win == 1));
    check("rsv_ready", ifc.rsv_ready, exp_rsv);
    check("stall", stall, exp_stall);
    @(posedge clk);
    #1;
    if (!Clear) begin
      model_reset();
    end else begin
      m_load = (win >= 0);
      if (win == 0) begin
        m_c = ifc.wb0_data; m_caddr = ifc.wb0_addr;
      end else if (win == 1) begin
        m_c = ifc.wb1_data; m_caddr = ifc.wb1_addr;
      end
      if (both) m_last = win;
      if (win >= 0) m_busy[m_caddr] = 1'b0;
      if (ifc.rsv_valid && exp_rsv) m_busy[ifc.rsv_addr] = 1'b1;
    end
    check("Load", Load, m_load);
    check("C", C, m_c);
    check("Caddr", Caddr, m_caddr);
  endtask

  initial begin
    int  w;
    bit  pend0, pend1;

    // Reset with both requesters valid
    Clear = 1'b0;
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 4'd9;  ifc.wb0_data = 16'hAAAA;
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 4'd10; ifc.wb1_data = 16'hBBBB;
    ifc.rsv_valid = 1'b0; ifc.rsv_addr = 4'd0;
    Aaddr = 4'd0; Baddr = 4'd0; Aen = 1'b0; Ben = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    cycle(w);
    cycle(w);
    check("rst_Load", Load, 0);
    check("rst_C", C, 0);
    check("rst_Caddr", Caddr, 0);

    // Single write from port 0
    Clear = 1'b1;
    ifc.wb1_valid = 1'b0;
    ifc.wb0_addr = 4'd4; ifc.wb0_data = 16'h0003;
    cycle(w);
    check("single_grant", w, 0);
    check("single_Load", Load, 1);
    check("single_Caddr", Caddr, 4);
    check("single_C", C, 16'h0003);
    ifc.wb0_valid = 1'b0;
    cycle(w);
    check("single_Load_drop", Load, 0);

    // Conflict held for four cycles: expect 0,1,0,1
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 4'd1; ifc.wb0_data = 16'h1111;
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 4'd2; ifc.wb1_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      cycle(w);
      check("conflict_order", w, i % 2);
      check("conflict_Caddr", Caddr, (i % 2 == 0) ? 1 : 2);
    end
    ifc.wb0_valid = 1'b0; ifc.wb1_valid = 1'b0;
    cycle(w);
    ifc.wb0_valid = 1'b1; ifc.wb1_valid = 1'b1;
    cycle(w);
    check("pair_first", Caddr, 1);
    cycle(w);
    check("pair_second", Caddr, 2);
    ifc.wb0_valid = 1'b0; ifc.wb1_valid = 1'b0;

    // RAW: reserve reg 5, read it, then memory writeback clears the stall
    ifc.rsv_valid = 1'b1; ifc.rsv_addr = 4'd5;
    cycle(w);
    ifc.rsv_valid = 1'b0;
    Aaddr = 4'd5; Aen = 1'b1;
    #1;
    check("raw_stall", stall, SB);
    cycle(w);
    ifc.wb1_valid = 1'b1; ifc.wb1_addr = 4'd5; ifc.wb1_data = 16'h5555;
    cycle(w);
    ifc.wb1_valid = 1'b0;
    #1;
    check("raw_Load", Load, 1);
    check("raw_Caddr", Caddr, 5);
    check("raw_C", C, 16'h5555);
    check("raw_stall_clear", stall, 0);
    cycle(w);
    Aen = 1'b0;

    // WAW: a second reservation of a busy register is refused
    ifc.rsv_valid = 1'b1; ifc.rsv_addr = 4'd5;
    cycle(w);
    #1;
    check("waw_rsv_ready", ifc.rsv_ready, !SB);
    cycle(w);
    // Same-cycle writeback and reservation of reg 7: set wins
    ifc.rsv_addr = 4'd7;
    ifc.wb0_valid = 1'b1; ifc.wb0_addr = 4'd7; ifc.wb0_data = 16'h0777;
    cycle(w);
    ifc.rsv_valid = 1'b0; ifc.wb0_valid = 1'b0;
    Baddr = 4'd7; Ben = 1'b1;
    #1;
    check("same_cycle_busy7", stall, SB);
    cycle(w);
    Ben = 1'b0;

    // Randomized traffic with mid-run reset; requesters hold while refused
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      Clear = (i % 97 == 50) ? 1'b0 : 1'b1;
      if (!pend0) begin
        ifc.wb0_valid = ($urandom_range(9) < 6);
        ifc.wb0_addr  = 4'($urandom_range(15));
        ifc.wb0_data  = 16'($urandom);
      end
      if (!pend1) begin
        ifc.wb1_valid = ($urandom_range(9) < 6);
        ifc.wb1_addr  = 4'($urandom_range(15));
        ifc.wb1_data  = 16'($urandom);
      end
      ifc.rsv_valid = ($urandom_range(9) < 3);
      ifc.rsv_addr  = 4'($urandom_range(15));
      Aaddr = 4'($urandom_range(15)); Aen = $urandom_range(1) == 1;
      Baddr = 4'($urandom_range(15)); Ben = $urandom_range(1) == 1;
      cycle(w);
      pend0 = ifc.wb0_valid && (w != 0);
      pend1 = ifc.wb1_valid && (w != 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
